// File: rtl/ring_noc_pkg.sv
// Shared ring NoC definitions: packet layout, packet type and buffer state.
package ring_noc_pkg;

  localparam int VC_BIT  = 63;
  localparam int DIR_BIT = 62;
  localparam int HOP_MSB = 25;
  localparam int HOP_LSB = 18;

  typedef logic [63:0] pkt_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

endpackage

// File: rtl/ring_pe_nic_if.sv
// PE-side bundle of the ring NIC: processor TX/RX handshakes and router PE port.
interface ring_pe_nic_if;
  import ring_noc_pkg::*;

  logic cpu_tx_valid;
  pkt_t cpu_tx_data;
  logic cpu_tx_ready;
  logic pesi;
  pkt_t pedi;
  logic peri;
  logic peso;
  pkt_t pedo;
  logic pero;
  logic cpu_rx_valid;
  pkt_t cpu_rx_data;
  logic cpu_rx_ready;

  // master: processor plus router PE port, seen from outside the NIC
  modport master (
    output cpu_tx_valid, cpu_tx_data, peri, peso, pedo, cpu_rx_ready,
    input  cpu_tx_ready, pesi, pedi, pero, cpu_rx_valid, cpu_rx_data
  );

  modport slave (
    input  cpu_tx_valid, cpu_tx_data, peri, peso, pedo, cpu_rx_ready,
    output cpu_tx_ready, pesi, pedi, pero, cpu_rx_valid, cpu_rx_data
  );
endinterface

// File: rtl/ring_vc_slot.sv
// Single-packet buffer with full flag; load has priority, callers never assert both.
module ring_vc_slot
  import ring_noc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic unload_i,
  input  pkt_t data_i,
  output logic full_o,
  output pkt_t data_o
);

  buf_state_e state_q;
  pkt_t       data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else if (load_i) begin
      state_q <= FULL;
      data_q  <= data_i;
    end else if (unload_i) begin
      state_q <= EMPTY;
    end
  end

  assign full_o = (state_q == FULL);
  assign data_o = data_q;

endmodule

// File: rtl/ring_pe_nic.sv
// Processor-side NIC for the bidirectional ring router PE port.
// Optional statistics counters built when RING_PE_NIC_STATS_EN is defined.
module ring_pe_nic
  import ring_noc_pkg::*;
#(
  parameter int DW  = 64,
  parameter int STW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  ring_pe_nic_if.slave      nic,
  output logic              err_hop,
  output logic [STW-1:0]    tx_count,
  output logic [STW-1:0]    rx_count
);

  logic [1:0] tx_full, tx_load, tx_unload;
  logic [1:0] rx_full, rx_load, rx_unload;
  pkt_t       tx_data [2];
  pkt_t       rx_data [2];
  logic [DW-1:0] tx_head;
  logic       tx_vc, tx_fire, rx_accept, rx_consume, rx_sel;
  logic       rr_q, err_hop_q;

  assign tx_vc            = nic.cpu_tx_data[VC_BIT];
  assign nic.cpu_tx_ready = ~tx_full[tx_vc];
  assign tx_head          = tx_data[polarity];
  assign nic.pesi         = tx_full[polarity];
  assign nic.pedi         = nic.pesi ? tx_head : '0;
  assign tx_fire          = nic.pesi & nic.peri;

  assign nic.pero   = ~rx_full[polarity];
  assign rx_accept  = nic.peso & nic.pero;

  // Both full: round-robin pointer decides; otherwise whichever one is full.
  assign rx_sel           = (&rx_full) ? rr_q : rx_full[1];
  assign nic.cpu_rx_valid = |rx_full;
  assign nic.cpu_rx_data  = nic.cpu_rx_valid ? rx_data[rx_sel] : '0;
  assign rx_consume       = nic.cpu_rx_valid & nic.cpu_rx_ready;

  always_comb begin
    tx_load   = '0;
    tx_unload = '0;
    rx_load   = '0;
    rx_unload = '0;
    tx_load[tx_vc]      = nic.cpu_tx_valid & nic.cpu_tx_ready;
    tx_unload[polarity] = tx_fire;
    rx_load[polarity]   = rx_accept;
    rx_unload[rx_sel]   = rx_consume;
  end

  for (genvar v = 0; v < 2; v++) begin : g_vc
    ring_vc_slot u_tx (
      .clk     (clk),
      .reset   (reset),
      .load_i  (tx_load[v]),
      .unload_i(tx_unload[v]),
      .data_i  (nic.cpu_tx_data),
      .full_o  (tx_full[v]),
      .data_o  (tx_data[v])
    );
    ring_vc_slot u_rx (
      .clk     (clk),
      .reset   (reset),
      .load_i  (rx_load[v]),
      .unload_i(rx_unload[v]),
      .data_i  (nic.pedo),
      .full_o  (rx_full[v]),
      .data_o  (rx_data[v])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q      <= 1'b0;
      err_hop_q <= 1'b0;
    end else begin
      if (rx_consume && (&rx_full)) rr_q <= ~rr_q;
      if (rx_accept && (|nic.pedo[HOP_MSB:HOP_LSB])) err_hop_q <= 1'b1;
    end
  end

  assign err_hop = err_hop_q;

`ifdef RING_PE_NIC_STATS_EN
  logic [STW-1:0] tx_cnt_q, rx_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_fire)   tx_cnt_q <= tx_cnt_q + 1'b1;
      if (rx_accept) rx_cnt_q <= rx_cnt_q + 1'b1;
    end
  end

  assign tx_count = tx_cnt_q;
  assign rx_count = rx_cnt_q;
`else
  assign tx_count = '0;
  assign rx_count = '0;
`endif

endmodule

// File: tb/tb_ring_pe_nic.sv
// Directed self-checking bench for ring_pe_nic; expected stats follow RING_PE_NIC_STATS_EN.
module tb_ring_pe_nic;
  import ring_noc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic        err_hop;
  logic [15:0] tx_count, rx_count;
  int          n_chk = 0;
  int          n_err = 0;

  ring_pe_nic_if nic_if ();

  ring_pe_nic #(.DW(64), .STW(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .polarity(polarity),
    .nic     (nic_if.slave),
    .err_hop (err_hop),
    .tx_count(tx_count),
    .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam pkt_t PKT_E   = 64'h0000_0000_0000_0001;
  localparam pkt_t PKT_O   = 64'h8000_0000_0000_00AA;
  localparam pkt_t PKT_A   = 64'h1111_0000_0000_0005;
  localparam pkt_t PKT_B   = 64'h2222_0000_0000_0007;
  localparam pkt_t PKT_HOP = 64'h0000_0000_000C_0000;

  logic [63:0] exp_tx_cnt, exp_rx_cnt;

  initial begin
`ifdef RING_PE_NIC_STATS_EN
    exp_tx_cnt = 64'd5;
    exp_rx_cnt = 64'd3;
`else
    exp_tx_cnt = 64'd0;
    exp_rx_cnt = 64'd0;
`endif
    reset = 1'b1;
    polarity = 1'b0;
    nic_if.cpu_tx_valid = 1'b0;
    nic_if.cpu_tx_data  = '0;
    nic_if.peri         = 1'b0;
    nic_if.peso         = 1'b0;
    nic_if.pedo         = '0;
    nic_if.cpu_rx_ready = 1'b0;
    #1;
    chk("rst_pesi",   nic_if.pesi, 0);
    chk("rst_pedi",   nic_if.pedi, 0);
    chk("rst_pero",   nic_if.pero, 1);
    chk("rst_txrdy",  nic_if.cpu_tx_ready, 1);
    chk("rst_rxval",  nic_if.cpu_rx_valid, 0);
    chk("rst_rxdata", nic_if.cpu_rx_data, 0);
    chk("rst_errhop", err_hop, 0);
    tick();
    tick();
    reset = 1'b0;

    // TX even slot
    polarity = 1'b1; nic_if.peri = 1'b1;
    nic_if.cpu_tx_valid = 1'b1; nic_if.cpu_tx_data = PKT_E;
    #1;
    chk("txe_ready", nic_if.cpu_tx_ready, 1);
    chk("txe_pesi_before", nic_if.pesi, 0);
    tick();
    nic_if.cpu_tx_valid = 1'b0; polarity = 1'b0;
    #1;
    chk("txe_pesi", nic_if.pesi, 1);
    chk("txe_pedi", nic_if.pedi, PKT_E);
    tick();
    polarity = 1'b1; #1;
    chk("txe_pesi_odd_after", nic_if.pesi, 0);
    polarity = 1'b0; #1;
    chk("txe_pesi_even_after", nic_if.pesi, 0);
    chk("txe_ready_after", nic_if.cpu_tx_ready, 1);

    // TX backpressure on VC1
    nic_if.peri = 1'b0;
    nic_if.cpu_tx_valid = 1'b1; nic_if.cpu_tx_data = PKT_O;
    #1;
    chk("txo_ready_load", nic_if.cpu_tx_ready, 1);
    tick();
    nic_if.cpu_tx_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      polarity = 1'b1; #1;
      chk("txo_pesi_odd", nic_if.pesi, 1);
      chk("txo_pedi_odd", nic_if.pedi, PKT_O);
      chk("txo_ready_hold", nic_if.cpu_tx_ready, 0);
      tick();
      polarity = 1'b0; #1;
      chk("txo_pesi_even", nic_if.pesi, 0);
      chk("txo_pedi_even", nic_if.pedi, 0);
      chk("txo_ready_hold", nic_if.cpu_tx_ready, 0);
      tick();
    end
    polarity = 1'b1; nic_if.peri = 1'b1; #1;
    chk("txo_pesi_go", nic_if.pesi, 1);
    tick();
    #1;
    chk("txo_pesi_done", nic_if.pesi, 0);
    chk("txo_ready_done", nic_if.cpu_tx_ready, 1);

    // RX both VCs, rr delivery
    polarity = 1'b0; nic_if.peso = 1'b1; nic_if.pedo = PKT_A; #1;
    chk("rx_pero_a", nic_if.pero, 1);
    tick();
    polarity = 1'b1; nic_if.pedo = PKT_B; #1;
    chk("rx_pero_b", nic_if.pero, 1);
    chk("rx_valid_a", nic_if.cpu_rx_valid, 1);
    chk("rx_data_a_only", nic_if.cpu_rx_data, PKT_A);
    tick();
    nic_if.peso = 1'b0; #1;
    chk("rx_pero_full1", nic_if.pero, 0);
    polarity = 1'b0; #1;
    chk("rx_pero_full0", nic_if.pero, 0);
    chk("rx_both_data_a", nic_if.cpu_rx_data, PKT_A);
    nic_if.cpu_rx_ready = 1'b1;
    tick();
    chk("rx_data_b", nic_if.cpu_rx_data, PKT_B);
    chk("rx_valid_b", nic_if.cpu_rx_valid, 1);
    tick();
    nic_if.cpu_rx_ready = 1'b0; #1;
    chk("rx_valid_empty", nic_if.cpu_rx_valid, 0);
    chk("rx_data_empty", nic_if.cpu_rx_data, 0);
    chk("rx_errhop_clean", err_hop, 0);

    // Hop error
    polarity = 1'b0; nic_if.peso = 1'b1; nic_if.pedo = PKT_HOP;
    tick();
    nic_if.peso = 1'b0; #1;
    chk("hop_err", err_hop, 1);
    chk("hop_valid", nic_if.cpu_rx_valid, 1);
    chk("hop_data", nic_if.cpu_rx_data, PKT_HOP);
    nic_if.cpu_rx_ready = 1'b1;
    tick();
    nic_if.cpu_rx_ready = 1'b0; #1;
    chk("hop_consumed", nic_if.cpu_rx_valid, 0);
    chk("hop_sticky", err_hop, 1);

    // Three more even sends for the statistics total
    nic_if.peri = 1'b1;
    for (int i = 0; i < 3; i++) begin
      polarity = 1'b0;
      nic_if.cpu_tx_valid = 1'b1; nic_if.cpu_tx_data = 64'(i + 2);
      tick();
      nic_if.cpu_tx_valid = 1'b0; #1;
      chk("stat_pedi", nic_if.pedi, 64'(i + 2));
      tick();
    end
    chk("stat_tx_count", 64'(tx_count), exp_tx_cnt);
    chk("stat_rx_count", 64'(rx_count), exp_rx_cnt);

    // Reset mid-flight with tx_buf[1] and rx_buf[0] full
    nic_if.peri = 1'b0; polarity = 1'b0;
    nic_if.cpu_tx_valid = 1'b1; nic_if.cpu_tx_data = 64'h8000_0000_0000_0055;
    tick();
    nic_if.cpu_tx_valid = 1'b0;
    nic_if.peso = 1'b1; nic_if.pedo = 64'h99;
    tick();
    nic_if.peso = 1'b0;
    polarity = 1'b1; #1;
    chk("mid_pesi_pre", nic_if.pesi, 1);
    polarity = 1'b0; #1;
    chk("mid_pero_pre", nic_if.pero, 0);
    chk("mid_valid_pre", nic_if.cpu_rx_valid, 1);
    #1;
    reset = 1'b1; #1;
    chk("mid_pero", nic_if.pero, 1);
    chk("mid_valid", nic_if.cpu_rx_valid, 0);
    chk("mid_data", nic_if.cpu_rx_data, 0);
    chk("mid_errhop", err_hop, 0);
    polarity = 1'b1; #1;
    chk("mid_pesi", nic_if.pesi, 0);
    chk("mid_tx_count", 64'(tx_count), 0);
    tick();
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ring_pe_nic.md
# ring_pe_nic

Processor-side network interface for the bidirectional ring router. It is the other end of the router's PE port:
- **Transmit:** accepts 64-bit packets from the local processor, holds them in per-virtual-channel injection buffers, and drives them onto the router's PE input (pedi/pesi/peri) only in the polarity slot matching each packet's VC.
- **Receive:** takes ejected packets from the router's PE output (pedo/peso/pero) into per-VC buffers and presents them to the processor through a valid/ready port.

## Interface
Parameters:
- DW, 64, packet width (fixed; field positions below assume 64)
- STW, 16, width of statistics counters

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- polarity  in  1  router cycle polarity: 0 = even slot, 1 = odd slot
- cpu_tx_valid  in  1  processor offers a packet
- cpu_tx_data  in  64  packet to inject
- cpu_tx_ready  out  1  injection buffer for VC cpu_tx_data[63] is empty
- pesi  out  1  send strobe to router PE input
- pedi  out  64  packet to router
- peri  in  1  router PE input ready
- peso  in  1  router eject strobe
- pedo  in  64  ejected packet
- pero  out  1  NIC can accept an ejected packet this cycle
- cpu_rx_valid  out  1  ejected packet available
- cpu_rx_data  out  64  ejected packet
- cpu_rx_ready  in  1  processor consumes
- err_hop  out  1  sticky: an ejected packet had nonzero hop field
- tx_count, rx_count  out  STW  statistics (macro-gated)

## Operation
Packet fields:
- [63] VC: 0 = even, 1 = odd
- [62] direction: 0 = cw, 1 = ccw
- [25:18] hop count
- All other bits are opaque.
- The NIC forwards every bit unmodified in both directions.

TX path:
- Buffers tx_buf[0..1], each with state TX_EMPTY or TX_FULL.
- Load: cpu_tx_valid & cpu_tx_ready at posedge loads tx_buf[v] (v = cpu_tx_data[63]) and sets it FULL.
- Send slot: in a cycle where tx_buf[polarity] is FULL, assert pesi=1 and drive pedi=tx_buf[polarity].
- Otherwise pesi=0 and pedi=0.
- pesi/pedi are combinational from registered state and polarity.
- Transfer completes at a posedge with pesi & peri; the buffer then returns to TX_EMPTY.
- If peri=0 the packet is retried in the next slot of the same polarity.
- While holding, the other VC's buffer may send in its own slot, so no head-of-line blocking across VCs.
- A load and a send on the same VC in the same cycle is impossible, because ready requires EMPTY.

RX path:
- Buffers rx_buf[0..1], each with state RX_EMPTY or RX_FULL.
- pero = ~rx_full[polarity], combinational from registered state.
- peso & pero at posedge loads rx_buf[polarity] and sets it FULL. The VC is implied by polarity, not by pedo[63].
- peso while pero=0 is a router protocol violation: the packet is ignored and no state changes.
- If pedo[25:18] != 0 on an accepted packet, set err_hop. It clears only on reset.

RX arbitration to the processor:
- cpu_rx_valid = rx_full[0] | rx_full[1].
- If exactly one buffer is full, present it.
- If both are full, present the one indicated by a round-robin pointer rr.
- rr flips to the other VC after each consumed packet when both were full.
- A consume and an eject to the same buffer in the same posedge is impossible, because pero requires EMPTY. A consume on one VC and an eject on the other VC in the same posedge are both honoured.

## Timing
- Reset values: all buffers EMPTY, rr=0, err_hop=0, counters 0. Consequently pesi=0, pedi=0, pero=1, cpu_tx_ready=1, cpu_rx_valid=0, cpu_rx_data=0.
- TX latency: at least 1 cycle from load to pesi. pesi rises in the first cycle after load whose polarity equals the VC, i.e. 1 or 2 cycles if peri stays high.
- RX latency: cpu_rx_valid rises the cycle after the accepting posedge.
- Throughput: one injection and one ejection per cycle in steady state, alternating VCs.
- Reset mid-operation: buffered packets are discarded. Outputs return to their reset values asynchronously.

## Configuration
- RING_PE_NIC_STATS_EN defined:
  - tx_count increments on each pesi & peri.
  - rx_count increments on each peso & pero.
  - Both wrap modulo 2^STW.
- Undefined: counter registers are not built and tx_count/rx_count are tied to 0.

## Structure
- Shared package ring_noc_pkg:
  - Packet field constants: VC_BIT=63, DIR_BIT=62, HOP_MSB=25, HOP_LSB=18.
  - Typedef for the 64-bit packet.
  - Buffer state enum {EMPTY, FULL}.
- One natural sub-module, ring_vc_slot: a single 64-bit buffer with a full flag and load/unload strobes. It is instantiated four times (2 TX, 2 RX).

## Test plan
- TX even slot: load 0x0000_0000_0000_0001 at polarity=1, peri=1. pesi=1 with pedi=…0001 in the next cycle (polarity=0). tx_buf[0] is empty after that edge.
- TX backpressure: odd packet 0x8000_0000_0000_00AA with peri=0 for 2 odd slots. pesi is asserted in each odd slot and is 0 in even slots; the packet is sent on the first odd slot with peri=1. cpu_tx_ready for VC1 stays 0 throughout.
- RX both VCs: eject A (polarity 0) then B (polarity 1) with cpu_rx_ready=0. Both buffers are full and pero=0 on both polarities. Raising ready delivers A then B via rr.
- Hop error: eject a packet with [25:18]=0x03. err_hop=1 and stays 1 until reset; the packet is still delivered.
- Reset mid-flight: assert reset with tx_buf[1] and rx_buf[0] full. pesi=0, pero=1, cpu_rx_valid=0 immediately.
- Stats (macro defined): 5 sends and 3 receives give tx_count=5 and rx_count=3. With the macro undefined, both read 0.
